// File: rtl/bf_pkg.sv
// rtl/bf_pkg.sv - shared widths and return-FSM encoding for the data arbiter
package bf_pkg;

  localparam int BF_AWIDTH = 12;
  localparam int BF_DWIDTH = 16;

  typedef enum logic [1:0] {
    RET_IDLE    = 2'd0,
    RET_CPU_RD  = 2'd1,
    RET_HOST_RD = 2'd2
  } ret_state_e;

endpackage

// File: rtl/bf_out_fifo.sv
// rtl/bf_out_fifo.sv - output stream FIFO fed by core writes
// Power-of-two depth; storage is not reset, only pointers and occupancy.
module bf_out_fifo #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [DWIDTH-1:0] data,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  // a full FIFO still takes the word when a pop frees a slot in the same cycle
  assign do_push = push & (~full | do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign data = mem_q[rd_ptr_q];

endmodule

// File: rtl/bf_data_arbiter.sv
// rtl/bf_data_arbiter.sv - data SRAM arbiter between core and host, plus core stream ports
// The core owns the SRAM whenever it asks; the host fills idle cycles.
module bf_data_arbiter
  import bf_pkg::*;
#(
  parameter int AWIDTH      = BF_AWIDTH,
  parameter int DWIDTH      = BF_DWIDTH,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] cpu_adr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  input  logic              cpu_w_req,
  input  logic              cpu_w_sel,
  input  logic              cpu_r_req,
  input  logic              cpu_r_sel,
  output logic [DWIDTH-1:0] cpu_rdata,
  output logic              cpu_den,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [AWIDTH-1:0] host_adr,
  input  logic [DWIDTH-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DWIDTH-1:0] host_rdata,
  output logic              host_rvalid,
  output logic [AWIDTH-1:0] mem_adr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ovf
);

  ret_state_e state_q, state_d;
  logic       ovf_q, ovf_d;
  logic       cpu_mem_wr, cpu_mem_rd, cpu_mem_acc, cpu_in_rd;
  logic       host_grant;
  logic       ofifo_push, ofifo_full, ofifo_empty;

  assign cpu_mem_wr  = cpu_w_req & ~cpu_w_sel;
  assign cpu_mem_rd  = cpu_r_req & ~cpu_r_sel;
  assign cpu_mem_acc = cpu_mem_wr | cpu_mem_rd;
  assign cpu_in_rd   = cpu_r_req & cpu_r_sel;
  assign host_grant  = host_req & ~cpu_mem_acc;
  assign host_gnt    = host_grant;

  always_comb begin
    if (cpu_mem_acc) begin
      mem_adr   = cpu_adr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_mem_wr;
      mem_re    = cpu_mem_rd;
    end else begin
      mem_adr   = host_adr;
      mem_wdata = host_wdata;
      mem_we    = host_grant & host_we;
      mem_re    = host_grant & ~host_we;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RET_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = RET_IDLE;
    if (cpu_mem_rd) begin
      state_d = RET_CPU_RD;
    end else if (host_grant && !host_we) begin
      state_d = RET_HOST_RD;
    end
  end

  always_comb begin
    cpu_rdata   = '0;
    cpu_den     = 1'b0;
    in_ready    = 1'b0;
    host_rdata  = '0;
    host_rvalid = 1'b0;
    case (state_q)
      RET_CPU_RD: begin
        cpu_rdata = mem_rdata;
        cpu_den   = 1'b1;
      end
      RET_HOST_RD: begin
        host_rdata  = mem_rdata;
        host_rvalid = 1'b1;
      end
      default: ;
    endcase
    // a pending memory return owns cpu_rdata; the stream word stays unconsumed
    if (cpu_in_rd && state_q != RET_CPU_RD) begin
      in_ready  = 1'b1;
      cpu_den   = in_valid;
      cpu_rdata = in_valid ? in_data : '0;
    end
  end

  assign ofifo_push = cpu_w_req & cpu_w_sel;
  assign out_valid  = ~ofifo_empty;

  bf_out_fifo #(
    .DWIDTH(DWIDTH),
    .DEPTH (OFIFO_DEPTH)
  ) u_out_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (ofifo_push),
    .push_data(cpu_wdata),
    .pop      (out_ready),
    .data     (out_data),
    .full     (ofifo_full),
    .empty    (ofifo_empty)
  );

  assign ovf_d = ovf_q | (ofifo_push & ofifo_full & ~out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;

endmodule

// File: tb/tb_bf_data_arbiter.sv
// tb/tb_bf_data_arbiter.sv - self-checking bench for bf_data_arbiter
module tb_bf_data_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] cpu_adr, host_adr, mem_adr;
  logic [15:0] cpu_wdata, cpu_rdata, host_wdata, host_rdata;
  logic [15:0] mem_wdata, mem_rdata, in_data, out_data;
  logic        cpu_w_req, cpu_w_sel, cpu_r_req, cpu_r_sel, cpu_den;
  logic        host_req, host_we, host_gnt, host_rvalid;
  logic        mem_we, mem_re, in_valid, in_ready, out_valid, out_ready, ovf;

  int total = 0;
  int bad   = 0;

  logic [15:0] sram    [4096];
  logic [15:0] ref_mem [32];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) sram[mem_adr] <= mem_wdata;
    if (mem_re) mem_rdata <= sram[mem_adr];
  end

  bf_data_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_w_req(cpu_w_req), .cpu_w_sel(cpu_w_sel),
    .cpu_r_req(cpu_r_req), .cpu_r_sel(cpu_r_sel),
    .cpu_rdata(cpu_rdata), .cpu_den(cpu_den),
    .host_req(host_req), .host_we(host_we), .host_adr(host_adr),
    .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ovf(ovf)
  );

  task automatic idle_inputs();
    cpu_adr = '0; cpu_wdata = '0; cpu_w_req = 0; cpu_w_sel = 0;
    cpu_r_req = 0; cpu_r_sel = 0; host_req = 0; host_we = 0;
    host_adr = '0; host_wdata = '0; in_data = '0; in_valid = 0; out_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    #1;
    total++;
    if (cpu_den !== 0 || cpu_rdata !== 16'h0 || host_rvalid !== 0) begin
      bad++; $display("FAIL reset_returns: den=%b rdata=%h rvalid=%b expected 0/0000/0", cpu_den, cpu_rdata, host_rvalid);
    end
    total++;
    if (out_valid !== 0 || ovf !== 0) begin
      bad++; $display("FAIL reset_fifo: out_valid=%b ovf=%b expected 0/0", out_valid, ovf);
    end
    @(negedge clk);
    rst = 0;
    #1;
    total++;
    if (mem_we !== 0 || mem_re !== 0 || host_gnt !== 0) begin
      bad++; $display("FAIL reset_idle_port: we=%b re=%b gnt=%b expected 0/0/0", mem_we, mem_re, host_gnt);
    end
  endtask

  task automatic test_cpu_read();
    sram[5] = 16'h1234;
    @(negedge clk);
    cpu_r_req = 1; cpu_r_sel = 0; cpu_adr = 12'h005;
    #1;
    total++;
    if (mem_re !== 1 || mem_adr !== 12'h005 || cpu_den !== 0) begin
      bad++; $display("FAIL cpu_rd_issue: re=%b adr=%h den=%b expected 1/005/0", mem_re, mem_adr, cpu_den);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    total++;
    if (cpu_den !== 1 || cpu_rdata !== 16'h1234) begin
      bad++; $display("FAIL cpu_rd_return: den=%b rdata=%h expected 1/1234", cpu_den, cpu_rdata);
    end
    @(negedge clk);
    #1;
    total++;
    if (cpu_den !== 0) begin
      bad++; $display("FAIL cpu_rd_single: den=%b expected 0", cpu_den);
    end
  endtask

  task automatic test_host_starve();
    @(negedge clk);
    host_req = 1; host_we = 1; host_adr = 12'h00A; host_wdata = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      cpu_w_req = 1; cpu_w_sel = 0; cpu_adr = 12'h100 + 12'(i); cpu_wdata = 16'h0100 + 16'(i);
      #1;
      total++;
      if (host_gnt !== 0 || mem_adr !== cpu_adr) begin
        bad++; $display("FAIL host_blocked_%0d: gnt=%b adr=%h expected 0/%h", i, host_gnt, mem_adr, cpu_adr);
      end
      @(negedge clk);
    end
    cpu_w_req = 0;
    #1;
    total++;
    if (host_gnt !== 1 || mem_we !== 1 || mem_adr !== 12'h00A || mem_wdata !== 16'hBEEF) begin
      bad++; $display("FAIL host_wr_grant: gnt=%b we=%b adr=%h wd=%h expected 1/1/00a/beef", host_gnt, mem_we, mem_adr, mem_wdata);
    end
    @(negedge clk);
    host_we = 0;
    #1;
    total++;
    if (host_gnt !== 1 || mem_re !== 1) begin
      bad++; $display("FAIL host_rd_grant: gnt=%b re=%b expected 1/1", host_gnt, mem_re);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    total++;
    if (host_rvalid !== 1 || host_rdata !== 16'hBEEF || cpu_den !== 0) begin
      bad++; $display("FAIL host_rd_return: rvalid=%b rdata=%h den=%b expected 1/beef/0", host_rvalid, host_rdata, cpu_den);
    end
    @(negedge clk);
    #1;
    total++;
    if (host_rvalid !== 0) begin
      bad++; $display("FAIL host_rd_single: rvalid=%b expected 0", host_rvalid);
    end
  endtask

  task automatic test_input_read();
    @(negedge clk);
    #1;
    total++;
    if (in_ready !== 0) begin
      bad++; $display("FAIL in_ready_idle: got %b expected 0", in_ready);
    end
    cpu_r_req = 1; cpu_r_sel = 1; in_valid = 0; in_data = 16'h7777;
    #1;
    total++;
    if (cpu_rdata !== 16'h0 || cpu_den !== 0 || in_ready !== 1) begin
      bad++; $display("FAIL in_rd_empty: rdata=%h den=%b rdy=%b expected 0000/0/1", cpu_rdata, cpu_den, in_ready);
    end
    @(negedge clk);
    in_valid = 1; in_data = 16'h0041;
    cpu_w_req = 1; cpu_w_sel = 0; cpu_adr = 12'h020; cpu_wdata = 16'h5A5A;
    #1;
    total++;
    if (cpu_rdata !== 16'h0041 || cpu_den !== 1 || in_ready !== 1) begin
      bad++; $display("FAIL in_rd_valid: rdata=%h den=%b rdy=%b expected 0041/1/1", cpu_rdata, cpu_den, in_ready);
    end
    total++;
    if (mem_we !== 1 || mem_adr !== 12'h020 || mem_wdata !== 16'h5A5A) begin
      bad++; $display("FAIL in_rd_with_wr: we=%b adr=%h wd=%h expected 1/020/5a5a", mem_we, mem_adr, mem_wdata);
    end
    @(negedge clk);
    idle_inputs();
    cpu_r_req = 1; cpu_r_sel = 0; cpu_adr = 12'h020;
    @(negedge clk);
    idle_inputs();
    #1;
    total++;
    if (cpu_den !== 1 || cpu_rdata !== 16'h5A5A) begin
      bad++; $display("FAIL in_rd_wr_landed: den=%b rdata=%h expected 1/5a5a", cpu_den, cpu_rdata);
    end
  endtask

  task automatic test_fifo_ovf();
    logic [15:0] exp_w;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle_inputs();
      cpu_w_req = 1; cpu_w_sel = 1; cpu_wdata = 16'h0011 + 16'(i);
      #1;
      if (i == 4) begin
        total++;
        if (ovf !== 0) begin
          bad++; $display("FAIL ovf_early: got %b expected 0", ovf);
        end
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    total++;
    if (ovf !== 1 || out_valid !== 1) begin
      bad++; $display("FAIL ovf_set: ovf=%b out_valid=%b expected 1/1", ovf, out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      out_ready = 1;
      exp_w = 16'h0011 + 16'(i);
      #1;
      total++;
      if (out_valid !== 1 || out_data !== exp_w) begin
        bad++; $display("FAIL drain_%0d: valid=%b data=%h expected 1/%h", i, out_valid, out_data, exp_w);
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (out_valid !== 0 || ovf !== 1) begin
      bad++; $display("FAIL drain_end: valid=%b ovf=%b expected 0/1", out_valid, ovf);
    end
    out_ready = 0;
  endtask

  task automatic test_full_push_pop();
    logic [15:0] exp_w;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cpu_w_req = 1; cpu_w_sel = 1; cpu_wdata = 16'h0021 + 16'(i); out_ready = 0;
    end
    @(negedge clk);
    cpu_w_req = 1; cpu_w_sel = 1; cpu_wdata = 16'h0025; out_ready = 1;
    #1;
    total++;
    if (out_data !== 16'h0021) begin
      bad++; $display("FAIL full_head: data=%h expected 0021", out_data);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    total++;
    if (ovf !== 0) begin
      bad++; $display("FAIL full_push_pop_ovf: ovf=%b expected 0", ovf);
    end
    for (int i = 0; i < 4; i++) begin
      out_ready = 1;
      exp_w = 16'h0022 + 16'(i);
      #1;
      total++;
      if (out_valid !== 1 || out_data !== exp_w) begin
        bad++; $display("FAIL full_drain_%0d: valid=%b data=%h expected 1/%h", i, out_valid, out_data, exp_w);
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (out_valid !== 0) begin
      bad++; $display("FAIL full_occupancy: out_valid=%b expected 0 after 4 words", out_valid);
    end
    out_ready = 0;
  endtask

  task automatic test_reset_mid_read();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cpu_w_req = 1; cpu_w_sel = 1; cpu_wdata = 16'h0030 + 16'(i);
    end
    @(negedge clk);
    idle_inputs();
    host_req = 1; host_we = 0; host_adr = 12'h00A;
    #1;
    total++;
    if (host_gnt !== 1 || ovf !== 1) begin
      bad++; $display("FAIL rst_mid_setup: gnt=%b ovf=%b expected 1/1", host_gnt, ovf);
    end
    @(negedge clk);
    idle_inputs();
    rst = 1;
    #1;
    total++;
    if (host_rvalid !== 0) begin
      bad++; $display("FAIL rst_mid_async: rvalid=%b expected 0", host_rvalid);
    end
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (host_rvalid !== 0 || cpu_den !== 0 || ovf !== 0 || out_valid !== 0) begin
        bad++; $display("FAIL rst_mid_after_%0d: rvalid=%b den=%b ovf=%b out_valid=%b expected 0/0/0/0", i, host_rvalid, cpu_den, ovf, out_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic        h_active, h_we_m;
    logic [11:0] h_adr_m;
    logic [15:0] h_wd_m;
    logic        pc_valid, ph_valid, ovf_m, cmem, exp_gnt, in_rd, exp_den;
    logic [15:0] pc_data, ph_data, exp_rdata;
    logic [15:0] q[$];
    do_reset();
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      cpu_w_req = 1; cpu_w_sel = 0; cpu_adr = 12'(a); cpu_wdata = 16'($urandom);
      ref_mem[a] = cpu_wdata;
    end
    h_active = 0; h_we_m = 0; h_adr_m = '0; h_wd_m = '0;
    pc_valid = 0; ph_valid = 0; pc_data = '0; ph_data = '0; ovf_m = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (!h_active && $urandom_range(0, 2) == 0) begin
        h_active = 1;
        h_we_m = 1'($urandom);
        h_adr_m = 12'($urandom_range(0, 31));
        h_wd_m = 16'($urandom);
      end
      host_req = h_active; host_we = h_we_m; host_adr = h_adr_m; host_wdata = h_wd_m;
      cpu_w_req = ($urandom_range(0, 2) == 0);
      cpu_w_sel = 1'($urandom);
      cpu_r_req = ($urandom_range(0, 2) == 0);
      cpu_r_sel = pc_valid ? 1'b0 : 1'($urandom);
      if (cpu_r_req && !cpu_r_sel && cpu_w_req) cpu_w_sel = 1;
      cpu_adr = 12'($urandom_range(0, 31));
      cpu_wdata = 16'($urandom);
      in_valid = 1'($urandom); in_data = 16'($urandom);
      out_ready = ($urandom_range(0, 3) == 0);
      #1;
      cmem = (cpu_w_req && !cpu_w_sel) || (cpu_r_req && !cpu_r_sel);
      exp_gnt = h_active && !cmem;
      in_rd = cpu_r_req && cpu_r_sel;
      exp_den = pc_valid ? 1'b1 : (in_rd ? in_valid : 1'b0);
      exp_rdata = pc_valid ? pc_data : (in_valid ? in_data : 16'h0);
      total++;
      if (host_gnt !== exp_gnt) begin
        bad++; $display("FAIL rnd_gnt c%0d: got %b expected %b", cyc, host_gnt, exp_gnt);
      end
      total++;
      if (cpu_den !== exp_den || ((pc_valid || in_rd) && cpu_rdata !== exp_rdata)) begin
        bad++; $display("FAIL rnd_cpu c%0d: den=%b rdata=%h expected %b/%h", cyc, cpu_den, cpu_rdata, exp_den, exp_rdata);
      end
      total++;
      if (in_ready !== in_rd) begin
        bad++; $display("FAIL rnd_in_ready c%0d: got %b expected %b", cyc, in_ready, in_rd);
      end
      total++;
      if (host_rvalid !== ph_valid || (ph_valid && host_rdata !== ph_data)) begin
        bad++; $display("FAIL rnd_host_ret c%0d: rvalid=%b rdata=%h expected %b/%h", cyc, host_rvalid, host_rdata, ph_valid, ph_data);
      end
      total++;
      if (out_valid !== (q.size() != 0) || (q.size() != 0 && out_data !== q[0])) begin
        bad++; $display("FAIL rnd_out c%0d: valid=%b data=%h expected %b/%h", cyc, out_valid, out_data, q.size() != 0, (q.size() != 0) ? q[0] : 16'h0);
      end
      total++;
      if (ovf !== ovf_m) begin
        bad++; $display("FAIL rnd_ovf c%0d: got %b expected %b", cyc, ovf, ovf_m);
      end
      pc_valid = cpu_r_req && !cpu_r_sel;
      pc_data = ref_mem[cpu_adr[4:0]];
      ph_valid = exp_gnt && !h_we_m;
      ph_data = ref_mem[h_adr_m[4:0]];
      if (cpu_w_req && !cpu_w_sel) ref_mem[cpu_adr[4:0]] = cpu_wdata;
      else if (exp_gnt && h_we_m) ref_mem[h_adr_m[4:0]] = h_wd_m;
      if (exp_gnt) h_active = 0;
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (cpu_w_req && cpu_w_sel) begin
        if (q.size() < 4) q.push_back(cpu_wdata);
        else ovf_m = 1;
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) sram[a] = '0;
    mem_rdata = '0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_cpu_read();
    test_host_starve();
    test_input_read();
    test_fifo_ovf();
    test_full_push_pop();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
